// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: round-robin arbiter that captures one requester's UDP packet
// and launches it to a single transmitter using a send/ready handshake.
module udp_tx_scheduler #(
    parameter int          NUM_REQ        = 4,
    parameter int          DATA_WIDTH     = 64,
    parameter logic [15:0] BASE_PORT      = 16'd5000,
    parameter int          LAUNCH_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*8-1:0]          req_size,
    input  logic [NUM_REQ*16-1:0]         req_dest_port,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [7:0]                    tx_size,
    output logic [15:0]                   tx_src_port,
    output logic [15:0]                   tx_dest_port,
    output logic                          tx_send,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    active_id,
    output logic [15:0]                   pkt_count,
    output logic                          timeout_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT_DONE = 2'd2;
    logic [1:0]    state;
    logic [IW-1:0] rr_ptr, sel, j;
    logic          found;
    logic [CW-1:0] cnt;
    // Scanning offsets from high to low lets the nearest set bit after rr_ptr win.
    always_comb begin
        found = 1'b0;
        sel = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[j]) begin
                found = 1'b1;
                sel = j;
            end
        end
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            req_grant <= '0;
            tx_data <= '0;
            tx_size <= '0;
            tx_src_port <= '0;
            tx_dest_port <= '0;
            tx_send <= 1'b0;
            active_id <= '0;
            pkt_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_grant <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (tx_ready && found) begin
                    tx_data <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
                    tx_size <= req_size[sel*8 +: 8];
                    tx_dest_port <= req_dest_port[sel*16 +: 16];
                    tx_src_port <= BASE_PORT + 16'(sel);
                    req_grant <= NUM_REQ'(1) << sel;
                    active_id <= sel;
                    rr_ptr <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    cnt <= '0;
                    state <= LAUNCH;
                end
                // The transmitter only drops tx_ready after seeing tx_send, so ignore ready until we are sending.
                LAUNCH: if (tx_send && !tx_ready) begin
                    tx_send <= 1'b0;
                    state <= WAIT_DONE;
                end else if (cnt == CW'(LAUNCH_TIMEOUT)) begin
                    tx_send <= 1'b0;
                    timeout_err <= 1'b1;
                    state <= IDLE;
                end else begin
                    tx_send <= 1'b1;
                    cnt <= cnt + 1'b1;
                end
                WAIT_DONE: if (tx_ready) begin
                    pkt_count <= pkt_count + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
